// File: rtl/knight_motion.sv
// ---------------------------------------------------------------------------
// knight_motion
//
// Computes the knight sprite's centre position, animation status and facing
// once per video frame from decoded key levels. The results feed the player
// colour mapper directly.
//
// frame_clk (VGA vsync) is treated as an ordinary level in the Clk domain; its
// rising edge is detected here and every state update happens only on that
// one-Clk "tick". Outputs are registered, so they change one Clk after the
// frame_clk rise and hold steady between ticks.
//
// Ports:
//   Clk         in   system clock
//   Reset       in   synchronous, active-high reset
//   frame_clk   in   vsync level, rising edge marks a new frame
//   key_left    in   left key held
//   key_right   in   right key held
//   key_jump    in   jump key held
//   BallX       out  [9:0] knight centre X
//   BallY       out  [9:0] knight centre Y
//   Ball_sizeX  out  [9:0] sprite width (constant)
//   Ball_sizeY  out  [9:0] sprite height (constant)
//   BallStatus  out  [3:0] 0 idle, 1 walk, 2 jump, 3 fall
//   facing_left out  1 when the last horizontal move was to the left
// ---------------------------------------------------------------------------
module knight_motion #(
    parameter int X_START    = 320,
    parameter int Y_GROUND   = 400,
    parameter int Y_MIN      = 32,
    parameter int X_MIN      = 24,
    parameter int X_MAX      = 615,
    parameter int WALK_SPEED = 2,
    parameter int JUMP_V     = 12,
    parameter int GRAVITY    = 1,
    parameter int V_MAX      = 10,
    parameter int SIZE_X     = 50,
    parameter int SIZE_Y     = 64
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_jump,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [9:0] Ball_sizeX,
    output logic [9:0] Ball_sizeY,
    output logic [3:0] BallStatus,
    output logic       facing_left
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WALK = 2'd1;
    localparam logic [1:0] ST_JUMP = 2'd2;
    localparam logic [1:0] ST_FALL = 2'd3;

    // Position arithmetic is done in signed 11 bits so a step below zero
    // cannot wrap around before the clamp sees it.
    localparam logic signed [10:0] X_MIN_S    = 11'(X_MIN);
    localparam logic signed [10:0] X_MAX_S    = 11'(X_MAX);
    localparam logic signed [10:0] Y_MIN_S    = 11'(Y_MIN);
    localparam logic signed [10:0] Y_GROUND_S = 11'(Y_GROUND);
    localparam logic signed [10:0] WALK_S     = 11'(WALK_SPEED);
    localparam logic signed [5:0]  JUMP_VY    = -6'(JUMP_V);
    localparam logic signed [5:0]  GRAVITY_S  = 6'(GRAVITY);
    localparam logic signed [5:0]  V_MAX_S    = 6'(V_MAX);

    logic              fc_q;
    logic              tick;
    logic [1:0]        state;
    logic [1:0]        state_next;
    logic signed [5:0] vy;
    logic signed [5:0] vy_next;
    logic signed [5:0] vy_inc;
    logic              jump_armed;
    logic              jump_armed_next;
    logic              move_left;
    logic              move_right;
    logic              moving;
    logic signed [10:0] x_step;
    logic signed [10:0] x_sum;
    logic [9:0]        x_next;
    logic signed [10:0] y_sum;
    logic [9:0]        y_next;
    logic              facing_next;

    assign tick = frame_clk & ~fc_q;

    assign move_right = key_right & ~key_left;
    assign move_left  = key_left & ~key_right;
    assign moving     = move_right | move_left;

    assign Ball_sizeX = 10'(SIZE_X);
    assign Ball_sizeY = 10'(SIZE_Y);
    assign BallStatus = {2'b00, state};

    // Horizontal motion applies in every state, including mid-air.
    always_comb begin
        x_step = 11'sd0;
        if (move_right) begin
            x_step = WALK_S;
        end else if (move_left) begin
            x_step = -WALK_S;
        end
        x_sum = $signed({1'b0, BallX}) + x_step;
        if (x_sum < X_MIN_S) begin
            x_next = X_MIN_S[9:0];
        end else if (x_sum > X_MAX_S) begin
            x_next = X_MAX_S[9:0];
        end else begin
            x_next = x_sum[9:0];
        end

        facing_next = facing_left;
        if (move_left) begin
            facing_next = 1'b1;
        end else if (move_right) begin
            facing_next = 1'b0;
        end
    end

    // Vertical motion and status. Releasing jump re-arms it, so holding the
    // key produces a single jump; landing never launches on the same tick.
    always_comb begin
        state_next      = state;
        vy_next         = vy;
        y_next          = BallY;
        jump_armed_next = jump_armed | ~key_jump;
        vy_inc          = vy + GRAVITY_S;
        y_sum           = $signed({1'b0, BallY}) + 11'(vy);

        case (state)
            ST_IDLE, ST_WALK: begin
                if (key_jump && jump_armed) begin
                    state_next      = ST_JUMP;
                    vy_next         = JUMP_VY;
                    jump_armed_next = 1'b0;
                end else begin
                    state_next = moving ? ST_WALK : ST_IDLE;
                end
            end
            ST_JUMP: begin
                if (y_sum < Y_MIN_S) begin
                    y_next     = Y_MIN_S[9:0];
                    vy_next    = 6'sd0;
                    state_next = ST_FALL;
                end else begin
                    y_next  = y_sum[9:0];
                    vy_next = vy_inc;
                    if (!vy_inc[5]) begin
                        state_next = ST_FALL;
                    end
                end
            end
            ST_FALL: begin
                if (y_sum >= Y_GROUND_S) begin
                    y_next     = Y_GROUND_S[9:0];
                    vy_next    = 6'sd0;
                    state_next = moving ? ST_WALK : ST_IDLE;
                end else begin
                    y_next  = y_sum[9:0];
                    vy_next = (vy_inc > V_MAX_S) ? V_MAX_S : vy_inc;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // All state advances only on the frame tick; reset wins over a
    // coincident tick and also clears the edge detector.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fc_q        <= 1'b0;
            BallX       <= 10'(X_START);
            BallY       <= 10'(Y_GROUND);
            state       <= ST_IDLE;
            facing_left <= 1'b0;
            vy          <= 6'sd0;
            jump_armed  <= 1'b0;
        end else begin
            fc_q <= frame_clk;
            if (tick) begin
                BallX       <= x_next;
                BallY       <= y_next;
                state       <= state_next;
                facing_left <= facing_next;
                vy          <= vy_next;
                jump_armed  <= jump_armed_next;
            end
        end
    end

endmodule

// File: tb/tb_knight_motion.sv
// ---------------------------------------------------------------------------
// tb_knight_motion
//
// Drives frame ticks and key levels into knight_motion. Each tick (and each
// reset cycle) pushes the expected outputs, computed by a plain-arithmetic
// model of the knight's physics, into a queue. A monitor pops and compares
// whenever the DUT should have updated, and on every other cycle confirms the
// outputs held steady. Directed scenarios also compare outputs to fixed values.
// ---------------------------------------------------------------------------
module tb_knight_motion;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_clk = 1'b0;
    logic       key_left = 1'b0;
    logic       key_right = 1'b0;
    logic       key_jump = 1'b0;
    logic [9:0] BallX;
    logic [9:0] BallY;
    logic [9:0] Ball_sizeX;
    logic [9:0] Ball_sizeY;
    logic [3:0] BallStatus;
    logic       facing_left;

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] status;
        logic       facing;
    } frame_exp_t;

    frame_exp_t exp_q[$];

    // Reference model state: position, vertical speed, and whether airborne
    int m_x, m_y, m_vy, m_status;
    bit m_air, m_rising, m_armed, m_facing;

    always #5 Clk = ~Clk;

    knight_motion dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .key_left   (key_left),
        .key_right  (key_right),
        .key_jump   (key_jump),
        .BallX      (BallX),
        .BallY      (BallY),
        .Ball_sizeX (Ball_sizeX),
        .Ball_sizeY (Ball_sizeY),
        .BallStatus (BallStatus),
        .facing_left(facing_left)
    );

    task automatic check_output(input string name, input int actual, input int expected);
        checks_total++;
        if (actual == expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic frame_exp_t model_snapshot();
        frame_exp_t e;
        e.x      = 10'(m_x);
        e.y      = 10'(m_y);
        e.status = 4'(m_status);
        e.facing = m_facing;
        return e;
    endfunction

    task automatic model_reset();
        m_x = 320; m_y = 400; m_vy = 0; m_status = 0;
        m_air = 0; m_rising = 0; m_armed = 0; m_facing = 0;
    endtask

    // One frame of knight physics, written straight from the motion rules
    task automatic model_tick(input bit l, input bit r, input bit j);
        int dir;
        int ny;
        dir = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
        m_x = m_x + 2 * dir;
        if (m_x < 24) m_x = 24;
        if (m_x > 615) m_x = 615;
        if (dir == -1) m_facing = 1;
        if (dir == 1) m_facing = 0;

        if (!m_air) begin
            if (j && m_armed) begin
                m_air = 1; m_rising = 1; m_vy = -12; m_armed = 0;
            end
        end else if (m_rising) begin
            ny = m_y + m_vy;
            if (ny < 32) begin
                m_y = 32; m_vy = 0; m_rising = 0;
            end else begin
                m_y = ny;
                m_vy = m_vy + 1;
                if (m_vy >= 0) m_rising = 0;
            end
        end else begin
            if (m_y + m_vy >= 400) begin
                m_y = 400; m_vy = 0; m_air = 0;
            end else begin
                m_y = m_y + m_vy;
                m_vy = (m_vy + 1 > 10) ? 10 : m_vy + 1;
            end
        end
        if (!j) m_armed = 1;

        if (m_air) m_status = m_rising ? 2 : 3;
        else       m_status = (dir != 0) ? 1 : 0;
    endtask

    // One frame: raise frame_clk with the chosen keys, then idle a few cycles
    task automatic apply_stimulus(input bit l, input bit r, input bit j, input int gap);
        @(negedge Clk);
        key_left  = l;
        key_right = r;
        key_jump  = j;
        frame_clk = 1'b1;
        model_tick(l, r, j);
        exp_q.push_back(model_snapshot());
        @(negedge Clk);
        frame_clk = 1'b0;
        key_left  = 1'($urandom_range(0, 1));
        key_right = 1'($urandom_range(0, 1));
        key_jump  = 1'($urandom_range(0, 1));
        repeat (gap) @(negedge Clk);
    endtask

    task automatic apply_reset(input bit fc);
        @(negedge Clk);
        Reset     = 1'b1;
        frame_clk = fc;
        model_reset();
        exp_q.push_back(model_snapshot());
        @(negedge Clk);
        Reset     = 1'b0;
        frame_clk = 1'b0;
        @(negedge Clk);
    endtask

    // Scoreboard monitor: pops on cycles where the DUT must update, otherwise
    // confirms the outputs did not move.
    initial begin : monitor
        bit         fc_seen;
        bit         ev;
        bit         has_last;
        frame_exp_t last;
        fc_seen  = 0;
        has_last = 0;
        last     = '0;
        forever begin
            @(posedge Clk);
            ev      = Reset || (frame_clk && !fc_seen);
            fc_seen = Reset ? 1'b0 : frame_clk;
            #1;
            if (ev) begin
                if (exp_q.size() == 0) begin
                    check_output("sb_underflow", 1, 0);
                end else begin
                    last     = exp_q.pop_front();
                    has_last = 1;
                    check_output("sb_x", int'(BallX), int'(last.x));
                    check_output("sb_y", int'(BallY), int'(last.y));
                    check_output("sb_status", int'(BallStatus), int'(last.status));
                    check_output("sb_facing", int'(facing_left), int'(last.facing));
                end
            end else if (has_last) begin
                check_output("hold_x", int'(BallX), int'(last.x));
                check_output("hold_y", int'(BallY), int'(last.y));
                check_output("hold_status", int'(BallStatus), int'(last.status));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int min_y;
        int max_y;
        bit landed;

        apply_reset(1'b0);
        check_output("size_x", int'(Ball_sizeX), 50);
        check_output("size_y", int'(Ball_sizeY), 64);

        // Idle frames leave the knight parked at the start point
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(0, 0, 0, 1);
            check_output("idle_x", int'(BallX), 320);
            check_output("idle_y", int'(BallY), 400);
            check_output("idle_status", int'(BallStatus), 0);
            check_output("idle_facing", int'(facing_left), 0);
        end

        // Walk right and stop
        for (int i = 0; i < 10; i++) apply_stimulus(0, 1, 0, 1);
        check_output("walk_x", int'(BallX), 340);
        check_output("walk_status", int'(BallStatus), 1);
        apply_stimulus(0, 0, 0, 1);
        check_output("stop_status", int'(BallStatus), 0);
        check_output("stop_x", int'(BallX), 340);

        // Right clamp
        for (int i = 0; i < 136; i++) apply_stimulus(0, 1, 0, 0);
        check_output("pre_clamp_x", int'(BallX), 612);
        apply_stimulus(0, 1, 0, 1);
        check_output("clamp_r1", int'(BallX), 614);
        apply_stimulus(0, 1, 0, 1);
        check_output("clamp_r2", int'(BallX), 615);
        apply_stimulus(0, 1, 0, 1);
        check_output("clamp_r3", int'(BallX), 615);

        // Left clamp
        apply_reset(1'b0);
        for (int i = 0; i < 147; i++) apply_stimulus(1, 0, 0, 0);
        check_output("pre_clamp_l", int'(BallX), 26);
        check_output("facing_l", int'(facing_left), 1);
        apply_stimulus(1, 0, 0, 1);
        check_output("clamp_l1", int'(BallX), 24);
        apply_stimulus(1, 0, 0, 1);
        check_output("clamp_l2", int'(BallX), 24);
        apply_stimulus(0, 1, 1, 1);
        apply_stimulus(0, 0, 0, 1);
        for (int i = 0; i < 30 && BallStatus != 0; i++) apply_stimulus(0, 0, 0, 0);

        // Single pulsed jump: rise 12 frames to the apex then fall back
        apply_stimulus(0, 0, 0, 1);
        apply_stimulus(0, 0, 1, 1);
        check_output("launch_status", int'(BallStatus), 2);
        check_output("launch_y", int'(BallY), 400);
        min_y = 400;
        max_y = 0;
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(0, 0, 0, 1);
            if (int'(BallY) < min_y) min_y = int'(BallY);
            if (int'(BallY) > max_y) max_y = int'(BallY);
        end
        check_output("apex_y", int'(BallY), 322);
        check_output("apex_status", int'(BallStatus), 3);
        landed = 0;
        for (int i = 0; i < 40 && !landed; i++) begin
            apply_stimulus(0, 0, 0, 1);
            if (int'(BallY) < min_y) min_y = int'(BallY);
            if (int'(BallY) > max_y) max_y = int'(BallY);
            if (BallStatus == 4'd0) landed = 1;
        end
        check_output("landed", int'(landed), 1);
        check_output("land_y", int'(BallY), 400);
        check_output("jump_min_y", min_y, 322);
        check_output("jump_max_y", max_y, 400);

        // Held jump gives one jump only; release and press again to re-arm
        apply_stimulus(0, 0, 1, 1);
        check_output("held_launch", int'(BallStatus), 2);
        for (int i = 0; i < 40; i++) apply_stimulus(0, 0, 1, 0);
        check_output("held_status", int'(BallStatus), 0);
        check_output("held_y", int'(BallY), 400);
        apply_stimulus(0, 0, 0, 1);
        check_output("rearm_status", int'(BallStatus), 0);
        apply_stimulus(0, 0, 1, 1);
        check_output("rejump_status", int'(BallStatus), 2);

        // Reset mid-jump with a coincident frame edge
        for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 0, 1);
        check_output("midjump_y", int'(BallY), 350);
        check_output("midjump_status", int'(BallStatus), 2);
        apply_reset(1'b1);
        check_output("rst_y", int'(BallY), 400);
        check_output("rst_x", int'(BallX), 320);
        check_output("rst_status", int'(BallStatus), 0);
        check_output("rst_facing", int'(facing_left), 0);

        // Randomized frames with occasional resets
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                apply_reset(1'($urandom_range(0, 1)));
            end else begin
                apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               ($urandom_range(0, 9) < 3), $urandom_range(0, 3));
            end
        end

        repeat (3) @(negedge Clk);
        check_output("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
